pipeline_ctrl: RTL

//  Central stall/bubble sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/bubble sequencer for the 5-stage pipeline: merges dmem wait, MUL occupancy,
// load-use and imem wait into per-stage hold/bubble controls, with a dmem watchdog and stall counter.
module pipeline_ctrl #(
   parameter int unsigned MUL_LAT     = 4,
   parameter int unsigned MEM_TIMEOUT = 256,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_id,
   input  logic             mul_ex,
   input  logic             imem_ready,
   input  logic             dmem_req_mem,
   input  logic             dmem_ready,
   input  logic             cnt_clr,
   output logic             hold_if,
   output logic             hold_id,
   output logic             hold_ex,
   output logic             hold_mem,
   output logic             bubble_id,
   output logic             bubble_ex,
   output logic             bubble_mem,
   output logic             mul_done,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int unsigned MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam bit          MUL_MULTI = (MUL_LAT > 1);
   localparam logic [MCNT_W-1:0] MCNT_INIT = (MUL_LAT > 1) ? MCNT_W'(MUL_LAT - 2) : '0;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      StRun,
      StMulBusy,
      StMemWait
   } state_t;

   state_t            state_q, ret_q, eff_state;
   logic [MCNT_W-1:0] mcnt_q;
   logic [WCNT_W-1:0] wcnt_q;
   logic              mem_timeout_q;
   logic [CNT_W-1:0]  stall_q;

   logic mem_hold, mul_start, mul_busy, mul_hold, mul_end;

   // While in MEM_WAIT, the MUL bookkeeping continues from the state that was interrupted.
   always_comb begin
      eff_state = (state_q == StMemWait) ? ret_q : state_q;
      mem_hold  = dmem_req_mem & ~dmem_ready;
      mul_start = MUL_MULTI && (eff_state == StRun) && mul_ex;
      mul_busy  = (eff_state == StMulBusy) && (mcnt_q != '0);
      mul_hold  = mul_start | mul_busy;
      mul_end   = (eff_state == StMulBusy) && (mcnt_q == '0) && !mem_hold;
   end

   always_comb begin
      hold_if    = 1'b0;
      hold_id    = 1'b0;
      hold_ex    = 1'b0;
      hold_mem   = 1'b0;
      bubble_id  = 1'b0;
      bubble_ex  = 1'b0;
      bubble_mem = 1'b0;
      mul_done   = 1'b0;
      if (!rst_n) begin
         bubble_id  = 1'b1;
         bubble_ex  = 1'b1;
         bubble_mem = 1'b1;
      end else if (mem_hold) begin
         hold_if  = 1'b1;
         hold_id  = 1'b1;
         hold_ex  = 1'b1;
         hold_mem = 1'b1;
      end else if (mul_hold) begin
         hold_if    = 1'b1;
         hold_id    = 1'b1;
         hold_ex    = 1'b1;
         bubble_mem = 1'b1;
      end else begin
         mul_done = mul_end;
         if (load_use_id) begin
            hold_if   = 1'b1;
            hold_id   = 1'b1;
            bubble_ex = 1'b1;
         end else if (!imem_ready) begin
            hold_if   = 1'b1;
            bubble_id = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= StRun;
         ret_q         <= StRun;
         mcnt_q        <= '0;
         wcnt_q        <= '0;
         mem_timeout_q <= 1'b0;
         stall_q       <= '0;
      end else begin
         if (mem_hold) begin
            state_q <= StMemWait;
            ret_q   <= eff_state;
         end else if (mul_start) begin
            mcnt_q  <= MCNT_INIT;
            state_q <= StMulBusy;
         end else if (mul_busy) begin
            mcnt_q  <= mcnt_q - MCNT_W'(1);
            state_q <= StMulBusy;
         end else if (mul_end) begin
            state_q <= StRun;
         end else begin
            state_q <= eff_state;
         end

         if (mem_hold) begin
            if (wcnt_q != '1) begin
               wcnt_q <= wcnt_q + WCNT_W'(1);
            end
            if (wcnt_q >= WCNT_LAST) begin
               mem_timeout_q <= 1'b1;
            end
         end else begin
            wcnt_q <= '0;
         end

         if (cnt_clr) begin
            stall_q <= '0;
         end else if (hold_if && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
         end
      end
   end

   assign mem_timeout  = mem_timeout_q;
   assign stall_cycles = stall_q;

endmodule
